// File: rtl/ram_sync_if.sv
// Request/response bundle for the single-port synchronous RAM.
// The master drives address, data, mask and strobes; the RAM answers with
// registered read data, a read-valid strobe and a busy flag.
interface ram_sync_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] wmask;
  logic              we;
  logic              re;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              busy;

  modport master (
    output addr, wdata, wmask, we, re,
    input  rdata, rvalid, busy
  );

  modport slave (
    input  addr, wdata, wmask, we, re,
    output rdata, rvalid, busy
  );
endinterface

// File: rtl/ram_sync.sv
// Parametrised single-port synchronous RAM with per-bit write mask,
// write-first read-during-write, registered read data with a valid strobe
// and an optional zero-fill sequence that runs after every reset.
module ram_sync #(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 2,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  ram_sync_if.slave   bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] ptr, ptr_next;
  logic              clr_we;
  logic              idle;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;

  logic [DATA_W-1:0] mem [DEPTH];

  assign idle   = (state == IDLE);
  // Word as it looks after this cycle's masked write; also the write-first read value.
  assign merged = (mem[bus.addr] & ~bus.wmask) | (bus.wdata & bus.wmask);

  // State register and clear pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR_ON_RESET ? CLEAR : IDLE;
      ptr   <= '0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  // Next-state logic: walk the pointer through every word, then go idle.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next = state;
    ptr_next   = ptr;
    clr_we     = 1'b0;
    unique case (state)
      CLEAR: begin
        clr_we   = 1'b1;
        ptr_next = ptr + 1'b1;
        if (ptr == ADDR_W'(DEPTH - 1)) state_next = IDLE;
      end
      IDLE: ;
      default: state_next = IDLE;
    endcase
  end

  // Storage array: zero-fill while clearing, masked write while idle.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset branch; reset only starts the clear walk, so it maps onto plain RAM.
    if (!rst) begin
      if (clr_we) begin
        mem[ptr] <= '0;
      end else if (idle && bus.we) begin
        mem[bus.addr] <= merged;
      end
    end
  end

  // Registered read path; rdata holds its last value when no read happens.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= idle && bus.re;
      if (idle && bus.re) begin
        rdata_q <= bus.we ? merged : mem[bus.addr];
      end
    end
  end

  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
  assign bus.busy   = (state == CLEAR);
endmodule

// File: tb/tb_ram_sync.sv
// Self-checking bench for ram_sync. Three instances cover the default
// 4x8 clearing RAM, a 4x8 RAM that keeps contents across reset, and a
// 16x16 clearing RAM. A behavioural model tracks every instance and a
// compare process checks all outputs on each falling edge; directed
// literal checks pin the model on the hand-worked scenarios.
module tb_ram_sync;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Per-instance request variables (widest shape; narrowed at the ports).
  logic [3:0]  addr_v  [3];
  logic [15:0] wdata_v [3];
  logic [15:0] wmask_v [3];
  logic        we_v    [3];
  logic        re_v    [3];

  logic [15:0] got_rdata  [3];
  logic        got_rvalid [3];
  logic        got_busy   [3];

  ram_sync_if #(.DATA_W(8),  .ADDR_W(2)) if_a ();
  ram_sync_if #(.DATA_W(8),  .ADDR_W(2)) if_b ();
  ram_sync_if #(.DATA_W(16), .ADDR_W(4)) if_c ();

  assign if_a.addr  = addr_v[0][1:0];
  assign if_a.wdata = wdata_v[0][7:0];
  assign if_a.wmask = wmask_v[0][7:0];
  assign if_a.we    = we_v[0];
  assign if_a.re    = re_v[0];
  assign if_b.addr  = addr_v[1][1:0];
  assign if_b.wdata = wdata_v[1][7:0];
  assign if_b.wmask = wmask_v[1][7:0];
  assign if_b.we    = we_v[1];
  assign if_b.re    = re_v[1];
  assign if_c.addr  = addr_v[2];
  assign if_c.wdata = wdata_v[2];
  assign if_c.wmask = wmask_v[2];
  assign if_c.we    = we_v[2];
  assign if_c.re    = re_v[2];

  assign got_rdata[0]  = {8'h00, if_a.rdata};
  assign got_rdata[1]  = {8'h00, if_b.rdata};
  assign got_rdata[2]  = if_c.rdata;
  assign got_rvalid[0] = if_a.rvalid;
  assign got_rvalid[1] = if_b.rvalid;
  assign got_rvalid[2] = if_c.rvalid;
  assign got_busy[0]   = if_a.busy;
  assign got_busy[1]   = if_b.busy;
  assign got_busy[2]   = if_c.busy;

  ram_sync #(.DATA_W(8),  .ADDR_W(2), .CLEAR_ON_RESET(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  ram_sync #(.DATA_W(8),  .ADDR_W(2), .CLEAR_ON_RESET(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
  ram_sync #(.DATA_W(16), .ADDR_W(4), .CLEAR_ON_RESET(1'b1)) dut_c (.clk(clk), .rst(rst), .bus(if_c));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int depth_of(input int i);
    return (i == 2) ? 16 : 4;
  endfunction

  function automatic bit cor_of(input int i);
    return (i != 1);
  endfunction

  function automatic logic [15:0] width_mask(input int i);
    return (i == 2) ? 16'hFFFF : 16'h00FF;
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                        input logic [15:0] m);
    return (old & ~m) | (d & m);
  endfunction

  // Behavioural model: a word array, a count of clear cycles still owed,
  // and the expected read result.
  logic [15:0] mdl_mem   [3][16];
  int          mdl_clr   [3];
  logic [15:0] exp_rdata [3];
  logic        exp_rvalid[3];
  logic        model_ok = 1'b0;

  always @(posedge clk) begin
    if (rst) model_ok <= 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        mdl_clr[i]    <= cor_of(i) ? depth_of(i) : 0;
        exp_rdata[i]  <= '0;
        exp_rvalid[i] <= 1'b0;
        if (cor_of(i)) for (int k = 0; k < 16; k++) mdl_mem[i][k] <= '0;
      end else if (mdl_clr[i] != 0) begin
        mdl_clr[i]    <= mdl_clr[i] - 1;
        exp_rvalid[i] <= 1'b0;
      end else begin
        if (we_v[i])
          mdl_mem[i][addr_v[i]] <= merge(mdl_mem[i][addr_v[i]], wdata_v[i], wmask_v[i]) & width_mask(i);
        exp_rvalid[i] <= re_v[i];
        if (re_v[i])
          exp_rdata[i] <= we_v[i]
            ? (merge(mdl_mem[i][addr_v[i]], wdata_v[i], wmask_v[i]) & width_mask(i))
            : mdl_mem[i][addr_v[i]];
      end
    end
  end

  // Compare process: every output of every instance, every falling edge.
  always @(negedge clk) begin
    if (model_ok) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("model_busy%0d", i),   {15'd0, got_busy[i]},   {15'd0, mdl_clr[i] != 0});
        check($sformatf("model_rvalid%0d", i), {15'd0, got_rvalid[i]}, {15'd0, exp_rvalid[i]});
        check($sformatf("model_rdata%0d", i),  got_rdata[i],           exp_rdata[i]);
      end
    end
  end

  task automatic set_req(input int i, input logic w, input logic r, input logic [3:0] a,
                         input logic [15:0] d, input logic [15:0] m);
    we_v[i]    = w;
    re_v[i]    = r;
    addr_v[i]  = a;
    wdata_v[i] = d;
    wmask_v[i] = m;
  endtask

  task automatic idle_all();
    for (int i = 0; i < 3; i++) set_req(i, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    idle_all();
    tick();
    tick();
    check("reset_busy_a",   {15'd0, got_busy[0]},   16'd1);
    check("reset_busy_b",   {15'd0, got_busy[1]},   16'd0);
    check("reset_rvalid_a", {15'd0, got_rvalid[0]}, 16'd0);
    check("reset_rdata_a",  got_rdata[0],           16'h0000);

    // Release reset with requests pending on the clearing RAMs: they must be ignored.
    // Meanwhile initialise every word of the retaining RAM.
    rst = 1'b0;
    set_req(0, 1'b1, 1'b1, 4'd0, 16'h00FF, 16'h00FF);
    set_req(2, 1'b1, 1'b1, 4'd0, 16'hFFFF, 16'hFFFF);
    for (int n = 1; n <= 16; n++) begin
      if (n <= 4) set_req(1, 1'b1, 1'b0, 4'(n - 1), 16'(n * 16'h0011), 16'h00FF);
      else        set_req(1, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000);
      tick();
      if (n == 4) set_req(0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000);
      if (n <= 4) check($sformatf("clear_busy_a_%0d", n), {15'd0, got_busy[0]}, {15'd0, n < 4});
      check($sformatf("clear_busy_c_%0d", n), {15'd0, got_busy[2]}, {15'd0, n < 16});
      check($sformatf("clear_rvalid_c_%0d", n), {15'd0, got_rvalid[2]}, 16'd0);
    end
    idle_all();

    // Cleared words read back as zero, one result per cycle.
    for (int k = 0; k < 4; k++) begin
      set_req(0, 1'b0, 1'b1, 4'(k), 16'h0000, 16'h0000);
      tick();
      check($sformatf("clear_rdata_a_%0d", k), got_rdata[0], 16'h0000);
      check($sformatf("clear_rvalid_a_%0d", k), {15'd0, got_rvalid[0]}, 16'd1);
    end
    idle_all();
    tick();
    check("rvalid_drop_a", {15'd0, got_rvalid[0]}, 16'd0);

    // Masked write merge.
    set_req(0, 1'b1, 1'b0, 4'd2, 16'h00A5, 16'h00FF); tick();
    set_req(0, 1'b1, 1'b0, 4'd2, 16'h000F, 16'h000F); tick();
    set_req(0, 1'b0, 1'b1, 4'd2, 16'h0000, 16'h0000); tick();
    check("mask_rdata_a",  got_rdata[0], 16'h00AF);
    check("mask_rvalid_a", {15'd0, got_rvalid[0]}, 16'd1);
    idle_all(); tick();
    check("hold_rdata_a",  got_rdata[0], 16'h00AF);
    check("hold_rvalid_a", {15'd0, got_rvalid[0]}, 16'd0);

    // Write-first read during write.
    set_req(0, 1'b1, 1'b0, 4'd1, 16'h0033, 16'h00FF); tick();
    set_req(0, 1'b1, 1'b1, 4'd1, 16'h00C0, 16'h00F0); tick();
    check("wfirst_rdata_a", got_rdata[0], 16'h00C3);
    set_req(0, 1'b0, 1'b1, 4'd1, 16'h0000, 16'h0000); tick();
    check("wfirst_reread_a", got_rdata[0], 16'h00C3);

    // The write attempted while busy never landed.
    set_req(0, 1'b0, 1'b1, 4'd0, 16'h0000, 16'h0000); tick();
    check("busy_ignored_a", got_rdata[0], 16'h0000);
    idle_all();

    // Retained contents across reset, and reset in the middle of a clear.
    set_req(1, 1'b1, 1'b0, 4'd3, 16'h005A, 16'h00FF); tick();
    idle_all();
    rst = 1'b1; tick();
    rst = 1'b0; tick(); tick();
    rst = 1'b1; tick();
    check("rst_busy_b", {15'd0, got_busy[1]}, 16'd0);
    rst = 1'b0;
    set_req(1, 1'b0, 1'b1, 4'd3, 16'h0000, 16'h0000);
    tick();
    check("restart_busy_a_1", {15'd0, got_busy[0]}, 16'd1);
    check("retain_rdata_b",   got_rdata[1], 16'h005A);
    check("retain_rvalid_b",  {15'd0, got_rvalid[1]}, 16'd1);
    idle_all();
    for (int n = 2; n <= 4; n++) begin
      tick();
      check($sformatf("restart_busy_a_%0d", n), {15'd0, got_busy[0]}, {15'd0, n < 4});
    end
    for (int n = 5; n <= 16; n++) tick();
    check("restart_busy_c", {15'd0, got_busy[2]}, 16'd0);

    // Wide/deep instance: fill, then stream all words back.
    for (int k = 0; k < 16; k++) begin
      set_req(2, 1'b1, 1'b0, 4'(k), 16'(k * 16'h1111), 16'hFFFF);
      tick();
    end
    for (int k = 0; k < 16; k++) begin
      set_req(2, 1'b0, 1'b1, 4'(k), 16'h0000, 16'h0000);
      tick();
      check($sformatf("stream_rdata_c_%0d", k), got_rdata[2], 16'(k * 16'h1111));
      check($sformatf("stream_rvalid_c_%0d", k), {15'd0, got_rvalid[2]}, 16'd1);
    end
    idle_all(); tick();

    // Randomised traffic with occasional resets, checked by the model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < 3; i++)
        set_req(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                4'($urandom_range(0, depth_of(i) - 1)),
                16'($urandom), 16'($urandom));
      tick();
    end
    rst = 1'b0;
    idle_all();
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
